// File: rtl/led_pattern_reg.sv
// led_pattern_reg: WIDTH-bit LED pattern register with eight modes.
// A prescaler paces the animated modes; stepped flags each update.
module led_pattern_reg #(
  parameter int WIDTH = 8,
  parameter int DIV   = 4
) (
  input  logic             k,
  input  logic             reset,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] data,
  input  logic             sin,
  output logic [WIDTH-1:0] q,
  output logic             stepped
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  typedef enum logic [2:0] {
    HOLD   = 3'd0,
    LOAD   = 3'd1,
    SHL    = 3'd2,
    SHR    = 3'd3,
    ROL    = 3'd4,
    ROR    = 3'd5,
    BOUNCE = 3'd6,
    COUNT  = 3'd7
  } mode_t;

  logic [CW-1:0]    cnt;
  logic [2:0]       mode_q;
  logic             dir;
  logic [WIDTH-1:0] nq;
  logic             ndir;

  // Pattern value to apply if this edge turns out to be a step.
  always_comb begin
    nq   = q;
    ndir = dir;
    case (mode_t'(mode))
      SHL:   nq = {q[WIDTH-2:0], sin};
      SHR:   nq = {sin, q[WIDTH-1:1]};
      ROL:   nq = {q[WIDTH-2:0], q[WIDTH-1]};
      ROR:   nq = {q[0], q[WIDTH-1:1]};
      COUNT: nq = q + WIDTH'(1);
      BOUNCE: begin
        if (q == '0) begin
          nq   = WIDTH'(1);
          ndir = 1'b0;
        end else if (!dir) begin
          if (q[WIDTH-1]) begin
            ndir = 1'b1;
            nq   = q >> 1;
          end else begin
            nq = q << 1;
          end
        end else if (q[0]) begin
          ndir = 1'b0;
          nq   = q << 1;
        end else begin
          nq = q >> 1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge k) begin
    if (!reset) begin
      q       <= '0;
      cnt     <= '0;
      dir     <= 1'b0;
      mode_q  <= 3'd0;
      stepped <= 1'b0;
    end else if (mode != mode_q) begin
      // A mode change restarts the prescaler and never steps.
      mode_q  <= mode;
      cnt     <= '0;
      stepped <= 1'b0;
      if (mode == LOAD)
        q <= data;
    end else if (mode == HOLD || mode == LOAD) begin
      cnt     <= '0;
      stepped <= 1'b0;
      if (mode == LOAD) begin
        q   <= data;
        dir <= 1'b0;
      end
    end else if (!en) begin
      stepped <= 1'b0;
    end else if (cnt == LAST) begin
      cnt     <= '0;
      stepped <= 1'b1;
      q       <= nq;
      dir     <= ndir;
    end else begin
      cnt     <= cnt + CW'(1);
      stepped <= 1'b0;
    end
  end

endmodule

// File: tb/tb_led_pattern_reg.sv
// tb_led_pattern_reg: directed scoreboard bench for led_pattern_reg.
// Three instances (DIV=4,1,2) share the same stimulus.
module tb_led_pattern_reg;

  logic       k = 1'b0;
  logic       reset;
  logic       en;
  logic [2:0] mode;
  logic [7:0] data;
  logic       sin;

  logic [7:0] q4, q1, q2;
  logic       s4, s1, s2;

  typedef struct {
    string      tag;
    int         sel;
    logic [7:0] q;
    logic       st;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;

  always #5 k = ~k;

  led_pattern_reg #(.WIDTH(8), .DIV(4)) u4 (
    .k(k), .reset(reset), .en(en), .mode(mode),
    .data(data), .sin(sin), .q(q4), .stepped(s4)
  );
  led_pattern_reg #(.WIDTH(8), .DIV(1)) u1 (
    .k(k), .reset(reset), .en(en), .mode(mode),
    .data(data), .sin(sin), .q(q1), .stepped(s1)
  );
  led_pattern_reg #(.WIDTH(8), .DIV(2)) u2 (
    .k(k), .reset(reset), .en(en), .mode(mode),
    .data(data), .sin(sin), .q(q2), .stepped(s2)
  );

  task automatic push(input string tag, input int sel,
                      input logic [7:0] eq, input logic est);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.q   = eq;
    e.st  = est;
    sb.push_back(e);
  endtask

  task automatic drain();
    exp_t       e;
    logic [8:0] obs;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      case (e.sel)
        1:       obs = {q1, s1};
        2:       obs = {q2, s2};
        default: obs = {q4, s4};
      endcase
      vectors++;
      assert (obs === {e.q, e.st}) else begin
        miscompares++;
        $error("FAIL %s: q=%h stepped=%b, expected q=%h stepped=%b",
               e.tag, obs[8:1], obs[0], e.q, e.st);
      end
    end
  endtask

  // Advance one edge, sample #1 later, check everything queued.
  task automatic tick();
    @(posedge k);
    #1;
    drain();
  endtask

  initial begin
    reset = 1'b0; en = 1'b1; mode = 3'd0; data = 8'h00; sin = 1'b0;
    tick();
    tick();

    // Reset from a loaded A5
    reset = 1'b1; mode = 3'd1; data = 8'hA5;
    push("load_a5", 4, 8'hA5, 1'b0);
    tick();
    reset = 1'b0;
    push("rst_e1", 4, 8'h00, 1'b0);
    push("rst_e1_d1", 1, 8'h00, 1'b0);
    tick();
    push("rst_e2", 4, 8'h00, 1'b0);
    tick();
    reset = 1'b1; mode = 3'd0;
    push("hold_after_rst", 4, 8'h00, 1'b0);
    tick();
    push("hold_after_rst2", 4, 8'h00, 1'b0);
    tick();

    // LOAD 81 then ROL on DIV=4
    mode = 3'd1; data = 8'h81;
    push("load_81", 4, 8'h81, 1'b0);
    tick();
    mode = 3'd4;
    push("rol_e0", 4, 8'h81, 1'b0);
    tick();
    for (int i = 1; i <= 8; i++) begin
      if (i < 4)       push("rol_wait1", 4, 8'h81, 1'b0);
      else if (i == 4) push("rol_step1", 4, 8'h03, 1'b1);
      else if (i < 8)  push("rol_wait2", 4, 8'h03, 1'b0);
      else             push("rol_step2", 4, 8'h06, 1'b1);
      tick();
    end

    // SHR with sin=1 on DIV=1
    mode = 3'd1; data = 8'h00;
    push("load_00", 1, 8'h00, 1'b0);
    tick();
    mode = 3'd3; sin = 1'b1;
    push("shr_e0", 1, 8'h00, 1'b0);
    tick();
    push("shr_1", 1, 8'h80, 1'b1);
    tick();
    push("shr_2", 1, 8'hC0, 1'b1);
    tick();
    push("shr_3", 1, 8'hE0, 1'b1);
    tick();
    sin = 1'b0;

    // BOUNCE from 40 on DIV=1 (second LOAD edge clears dir)
    mode = 3'd1; data = 8'h40;
    push("load_40", 1, 8'h40, 1'b0);
    tick();
    push("load_40b", 1, 8'h40, 1'b0);
    tick();
    mode = 3'd6;
    push("bnc_e0", 1, 8'h40, 1'b0);
    tick();
    push("bnc_up", 1, 8'h80, 1'b1);
    tick();
    for (int i = 6; i >= 0; i--) begin
      push("bnc_down", 1, 8'(1 << i), 1'b1);
      tick();
    end
    push("bnc_turn", 1, 8'h02, 1'b1);
    tick();

    // COUNT wrap on DIV=2
    mode = 3'd1; data = 8'hFE;
    push("load_fe", 2, 8'hFE, 1'b0);
    tick();
    mode = 3'd7;
    push("cnt_e0", 2, 8'hFE, 1'b0);
    tick();
    push("cnt_e1", 2, 8'hFE, 1'b0);
    tick();
    push("cnt_ff", 2, 8'hFF, 1'b1);
    tick();
    push("cnt_e3", 2, 8'hFF, 1'b0);
    tick();
    push("cnt_wrap", 2, 8'h00, 1'b1);
    tick();

    // Prescaler freeze on DIV=4: en low 3 edges once cnt reaches 2
    mode = 3'd1; data = 8'h01;
    push("load_01", 4, 8'h01, 1'b0);
    tick();
    mode = 3'd2; en = 1'b1; sin = 1'b0;
    push("shl_e0", 4, 8'h01, 1'b0);
    tick();
    push("shl_c1", 4, 8'h01, 1'b0);
    tick();
    push("shl_c2", 4, 8'h01, 1'b0);
    tick();
    en = 1'b0; sin = 1'b1;
    for (int i = 0; i < 3; i++) begin
      push("shl_frozen", 4, 8'h01, 1'b0);
      tick();
    end
    en = 1'b1;
    push("shl_c3", 4, 8'h01, 1'b0);
    tick();
    sin = 1'b0;
    push("shl_step_late", 4, 8'h02, 1'b1);
    tick();

    // Mode change on the would-be step edge suppresses the step
    for (int i = 0; i < 3; i++) begin
      push("shl_run", 4, 8'h02, 1'b0);
      tick();
    end
    mode = 3'd4;
    push("chg_suppress", 4, 8'h02, 1'b0);
    tick();
    for (int i = 0; i < 3; i++) begin
      push("rol_restart", 4, 8'h02, 1'b0);
      tick();
    end
    push("rol_after_chg", 4, 8'h04, 1'b1);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
